// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin two-master arbiter sequencing strobe/wait/ack accesses on the port-mapped I/O bus
module io_bus_arbiter #(
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [5:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [5:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [1:0]  adhi,
  output logic [3:0]  adio,
  output logic        read,
  output logic        write,
  output logic [15:0] out_port,
  input  logic [15:0] in_port,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_ACK} state_t;
  state_t state, state_nx;
  logic last, gnt, we_q, grant, pick, pick_we, enter_ack;
  logic [3:0] cnt;
  logic [5:0] pick_addr;
  logic [15:0] pick_wdata;
  always_comb begin
    grant = state == S_IDLE && (m0_req || m1_req);
    pick = (m0_req && m1_req) ? !last : m1_req;
    pick_we = pick ? m1_we : m0_we;
    pick_addr = pick ? m1_addr : m0_addr;
    pick_wdata = pick ? m1_wdata : m0_wdata;
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = grant ? S_STROBE : S_IDLE;
      S_STROBE: state_nx = (WAIT_CYC > 0) ? S_WAIT : S_ACK;
      S_WAIT:   state_nx = (cnt == 4'd0) ? S_ACK : S_WAIT;
      default:  state_nx = S_IDLE;
    endcase
    enter_ack = state_nx == S_ACK;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  // strobes, acks and busy are registered from the next state so every output is a flop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last <= 1'b1;
      gnt <= 1'b0;
      we_q <= 1'b0;
      cnt <= 4'd0;
      adhi <= 2'd0;
      adio <= 4'd0;
      out_port <= 16'd0;
      read <= 1'b0;
      write <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_rdata <= 16'd0;
      m1_rdata <= 16'd0;
      busy <= 1'b0;
    end else begin
      read <= grant && !pick_we;
      write <= grant && pick_we;
      m0_ack <= enter_ack && !gnt;
      m1_ack <= enter_ack && gnt;
      busy <= state_nx != S_IDLE;
      if (grant) begin
        last <= pick;
        gnt <= pick;
        we_q <= pick_we;
        adhi <= pick_addr[5:4];
        adio <= pick_addr[3:0];
        out_port <= pick_wdata;
      end
      if (state == S_STROBE) cnt <= 4'(WAIT_CYC - 1);
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (enter_ack && !we_q && !gnt) m0_rdata <= in_port;
      if (enter_ack && !we_q && gnt) m1_rdata <= in_port;
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: scoreboard bench driving two arbiters (WAIT_CYC 2 and 0) against a transaction-level model
module tb_io_bus_arbiter;
  localparam int NA = 8192;
  typedef struct { int c; logic we; logic [5:0] addr; logic [15:0] wdata; } strobe_t;
  typedef struct { int c; int m; logic [15:0] rdata; } ack_t;
  logic clk = 0, reset = 0, rnd = 0;
  logic req [2][2];
  logic we [2][2];
  logic [5:0] addr [2][2];
  logic [15:0] wdata [2][2];
  logic [15:0] in_port [2];
  wire ack [2][2];
  wire [15:0] rdata [2][2];
  wire [1:0] adhi [2];
  wire [3:0] adio [2];
  wire rd [2];
  wire wr [2];
  wire busy [2];
  wire [15:0] out_port [2];
  int wc [2] = '{2, 0};
  logic [15:0] in_arr [2][NA];
  strobe_t sq [2][$];
  ack_t aq [2][$];
  int st [2][2];
  int keep [2][2];
  int ack_at [2][2];
  int free_at [2];
  int gnt_at [2];
  int busy_end [2];
  int last [2];
  logic [15:0] rdm [2][2];
  logic [15:0] shown [2][2];
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.WAIT_CYC(2)) u0 (
    .clk(clk), .reset(reset),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .adhi(adhi[0]), .adio(adio[0]), .read(rd[0]), .write(wr[0]),
    .out_port(out_port[0]), .in_port(in_port[0]), .busy(busy[0])
  );

  io_bus_arbiter #(.WAIT_CYC(0)) u1 (
    .clk(clk), .reset(reset),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .adhi(adhi[1]), .adio(adio[1]), .read(rd[1]), .write(wr[1]),
    .out_port(out_port[1]), .in_port(in_port[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    sq[d].delete();
    aq[d].delete();
    free_at[d] = 0;
    gnt_at[d] = -1;
    busy_end[d] = -2;
    last[d] = 1;
    for (int m = 0; m < 2; m++) begin
      st[d][m] = 0;
      keep[d][m] = 0;
      req[d][m] = 0;
      rdm[d][m] = 0;
      shown[d][m] = 0;
    end
  endtask

  // one grant per free bus slot; ack and read capture follow at fixed offsets from the grant edge
  task automatic model_edge(input int d);
    int m;
    strobe_t s;
    ack_t a;
    if (cyc < free_at[d] || !(req[d][0] || req[d][1])) return;
    m = (req[d][0] && req[d][1]) ? 1 - last[d] : (req[d][1] ? 1 : 0);
    last[d] = m;
    s.c = cyc;
    s.we = we[d][m];
    s.addr = addr[d][m];
    s.wdata = wdata[d][m];
    sq[d].push_back(s);
    if (!we[d][m]) rdm[d][m] = in_arr[d][cyc + wc[d]];
    a.c = cyc + 1 + wc[d];
    a.m = m;
    a.rdata = rdm[d][m];
    aq[d].push_back(a);
    gnt_at[d] = cyc;
    busy_end[d] = cyc + 1 + wc[d];
    free_at[d] = cyc + 3 + wc[d];
    st[d][m] = 2;
    ack_at[d][m] = a.c;
  endtask

  task automatic newreq(input int d, input int m);
    req[d][m] = 1;
    if (rnd) we[d][m] = 1'($urandom);
    addr[d][m] = 6'($urandom);
    wdata[d][m] = 16'($urandom);
    st[d][m] = 1;
  endtask

  task automatic drive(input int d);
    for (int m = 0; m < 2; m++)
      if (st[d][m] == 2 && cyc == ack_at[d][m]) begin
        if (rnd ? ($urandom_range(1) == 1) : (keep[d][m] > 0)) begin
          if (!rnd) keep[d][m]--;
          newreq(d, m);
        end else begin
          req[d][m] = 0;
          st[d][m] = 0;
        end
      end else if (st[d][m] == 2 && rnd) begin
        we[d][m] = 1'($urandom);
        addr[d][m] = 6'($urandom);
        wdata[d][m] = 16'($urandom);
        if ($urandom_range(7) == 0) req[d][m] = 0;
      end else if (st[d][m] == 0 && rnd && $urandom_range(3) == 0) newreq(d, m);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) if (!reset) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      drive(d);
      in_port[d] = in_arr[d][cyc];
    end
  endtask

  function automatic logic all_idle();
    logic r = 1;
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) if (st[d][m] != 0) r = 0;
    return r;
  endfunction

  task automatic idle_wait();
    for (int i = 0; i < 100 && !all_idle(); i++) step();
    chk("idle_reached", 0, 32'(all_idle()), 1);
  endtask

  always @(negedge clk) begin : mon
    strobe_t s;
    ack_t a;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk("reset_outputs", d, {ack[d][0], ack[d][1], rd[d], wr[d], busy[d], adhi[d], adio[d],
            out_port[d] | rdata[d][0] | rdata[d][1]}, 0);
      end else begin
        if (rd[d] || wr[d]) begin
          if (sq[d].size() == 0) chk("spurious_strobe", d, {rd[d], wr[d]}, 0);
          else begin
            s = sq[d].pop_front();
            chk("strobe_cycle", d, cyc, s.c);
            chk("strobe_rw", d, {rd[d], wr[d]}, {!s.we, s.we});
            chk("strobe_addr", d, {adhi[d], adio[d]}, s.addr);
            chk("strobe_wdata", d, out_port[d], s.wdata);
          end
        end else if (sq[d].size() > 0 && sq[d][0].c <= cyc) begin
          chk("strobe_missing", d, 32'(rd[d] | wr[d]), 1);
          void'(sq[d].pop_front());
        end
        if (ack[d][0] || ack[d][1]) begin
          if (aq[d].size() == 0) chk("spurious_ack", d, {ack[d][1], ack[d][0]}, 0);
          else begin
            a = aq[d].pop_front();
            chk("ack_cycle", d, cyc, a.c);
            chk("ack_master", d, {ack[d][1], ack[d][0]}, a.m == 1 ? 2 : 1);
            shown[d][a.m] = a.rdata;
          end
        end else if (aq[d].size() > 0 && aq[d][0].c <= cyc) begin
          chk("ack_missing", d, {ack[d][1], ack[d][0]}, aq[d][0].m == 1 ? 2 : 1);
          void'(aq[d].pop_front());
        end
        chk("m0_rdata", d, rdata[d][0], shown[d][0]);
        chk("m1_rdata", d, rdata[d][1], shown[d][1]);
        chk("busy", d, busy[d], cyc >= gnt_at[d] && cyc <= busy_end[d]);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NA; i++) in_arr[d][i] = 16'($urandom);
      for (int m = 0; m < 2; m++) begin
        we[d][m] = 0;
        addr[d][m] = 0;
        wdata[d][m] = 0;
      end
      in_port[d] = 0;
    end
    for (int i = 0; i < 64; i++) in_arr[0][i] = 16'h1234;
    #1 reset = 1;
    for (int d = 0; d < 2; d++) model_clear(d);
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      we[d][0] = 1;
      addr[d][0] = 6'h25;
      wdata[d][0] = 16'hBEEF;
      req[d][0] = 1;
      st[d][0] = 1;
    end
    repeat (2) step();
    reset = 0;
    idle_wait();
    for (int d = 0; d < 2; d++) begin
      we[d][1] = 0;
      addr[d][1] = 6'h0C;
      req[d][1] = 1;
      st[d][1] = 1;
    end
    idle_wait();
    for (int d = 0; d < 2; d++) begin
      we[d][1] = 1;
      addr[d][1] = 6'h0C;
      wdata[d][1] = 16'h5555;
      req[d][1] = 1;
      st[d][1] = 1;
    end
    idle_wait();
    for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) begin
      we[d][m] = 1'($urandom);
      keep[d][m] = 1;
      newreq(d, m);
    end
    idle_wait();
    for (int d = 0; d < 2; d++) begin
      we[d][0] = 0;
      keep[d][0] = 2;
      newreq(d, 0);
    end
    idle_wait();
    for (int d = 0; d < 2; d++) begin
      we[d][1] = 0;
      newreq(d, 1);
    end
    for (int i = 0; i < 10 && st[0][1] != 2; i++) step();
    step();
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      we[d][0] = 0;
      newreq(d, 0);
      we[d][1] = 1;
      newreq(d, 1);
    end
    repeat (2) step();
    reset = 0;
    idle_wait();
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        reset = 1;
        for (int d = 0; d < 2; d++) model_clear(d);
      end
      if (i == 1503) reset = 0;
    end
    rnd = 0;
    idle_wait();
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      chk("strobe_queue_drained", d, sq[d].size(), 0);
      chk("ack_queue_drained", d, aq[d].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
